round_key_store: RTL and testbench
==================================

// Module: round_key_store
// PURPOSE
//  Iterative AES-128 key schedule with an 11-entry round-key register file.
//  Accepts a cipher key via valid/ready and computes one round key per cycle using
//  the existing key_gen stage: slot[i+1] = key_gen(i, slot[i]), for i = 0..9.
//  Serves stored round keys to the iterative decryption datapath through a
//  registered read port, in decryption order by default.
// PARAMETERS
//  REVERSE  1  1: rd_idx n returns slot[10-n] (decrypt order); 0: rd_idx n returns slot[n]
// PORTS
//  clk        in   1    clock; all state updates on rising edge
//  rst        in   1    synchronous reset, active-high
//  key_in     in   128  cipher key (round 0 key), MSB = first byte
//  key_valid  in   1    key_in valid
//  key_ready  out  1    block can accept a key this cycle
//  busy       out  1    expansion in progress
//  keys_ready out  1    all 11 slots valid for the currently loaded key
//  rd_en      in   1    read request
//  rd_idx     in   4    round index 0..10
//  rd_key     out  128  registered round key
//  rd_valid   out  1    rd_key/rd_err valid; pulses 1 cycle after rd_en
//  rd_err     out  1    with rd_valid: rd_idx > 10 or keys_ready was 0
// BEHAVIOUR
//  Reset: state=IDLE, cnt=0, key_ready=1, busy=0, keys_ready=0, rd_key=0,
//   rd_valid=0, rd_err=0. Slot contents are not cleared.
//  FSM IDLE/EXPAND/READY. key_ready=1 in IDLE and READY, 0 in EXPAND.
//  Load: key_valid&&key_ready at edge -> slot[0]<=key_in, cnt<=0, state<=EXPAND,
//   keys_ready<=0, busy<=1.
//  EXPAND: each cycle slot[cnt+1]<=key_gen(cnt,slot[cnt]), cnt<=cnt+1. The cycle
//   with cnt==9 writes slot[10], sets state<=READY, keys_ready<=1, busy<=0.
//  Latency: keys_ready rises exactly 10 cycles after the load edge.
//  key_valid during EXPAND is ignored: no stall and no queueing.
//  key_valid in READY reloads and restarts: keys_ready drops on the same edge.
//  Read: rd_en at edge N -> rd_valid=1 at edge N+1.
//   - rd_key = slot[REVERSE ? 10-rd_idx : rd_idx], sampled from pre-edge contents.
//   - If rd_idx>10 or keys_ready==0 at edge N: rd_key=0 and rd_err=1.
//   - Without rd_en: rd_valid=0 and rd_err=0; rd_key holds its last value.
//  Read and load on the same edge in READY: the read is checked against the
//   pre-edge keys_ready (=1), so it returns the old key's slot with rd_err=0.
//  Reset mid-EXPAND: state returns to IDLE and keys_ready=0. A new load then
//   recomputes all slots.
//  key_gen round arg is cnt[3:0] (0..9); Rcon selection lives inside key_gen.
//  The slot file is plain registers (11x128). One key_gen instance only.
// TESTING
//  1 FIPS-197 key 2b7e151628aed2a6abf7158809cf4f3c, REVERSE=0:
//    - keys_ready high at load+10.
//    - rd_idx=1 -> a0fafe1788542cb123a339392a6c7605.
//    - rd_idx=10 -> d014f9a8c9ee2589e13f0cc8b6630ca6.
//  2 Same key, REVERSE=1:
//    - rd_idx=0 -> d014f9a8c9ee2589e13f0cc8b6630ca6.
//    - rd_idx=10 -> 2b7e151628aed2a6abf7158809cf4f3c.
//  3 All-zero key, REVERSE=0:
//    - rd_idx=1 -> 62636363626363636263636362636363.
//    - rd_idx=10 -> b4ef5bcb3e92e21123e951cf6f8f188e.
//  4 Read errors:
//    - rd_en with rd_idx=11 in READY -> rd_valid=1, rd_err=1, rd_key=0.
//    - rd_en during EXPAND -> rd_err=1.
//  5 Load key A, assert rst at cycle 5 of EXPAND, then load key B:
//    - keys_ready stays 0 until B's load+10.
//    - All 11 slots match B's schedule.
//  6 In READY with key A, load key B and rd_en(idx=10, REVERSE=0) on the same edge:
//    - That read returns A's round-10 key with rd_err=0.
//    - keys_ready drops on that edge.
//    - Key B's round-10 key is readable after load+10.

Source files
------------

// File: rtl/round_key_store.sv
// AES-128 iterative key expansion into an 11-slot round-key file.
// One key_gen step per cycle; a registered read port serves the stored keys.

module key_gen (
    input  logic [3:0]   round,
    input  logic [127:0] key_in,
    output logic [127:0] key_out
);

    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (8'h1b & {8{a[7]}});
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] r;
        logic [7:0] p;
        r = 8'h00;
        p = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) r = r ^ p;
            p = xt(p);
        end
        return r;
    endfunction

    // Multiplicative inverse as a^254; zero maps to zero.
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] r;
        logic [7:0] p;
        logic [7:0] e;
        r = 8'h01;
        p = a;
        e = 8'hfe;
        for (int i = 0; i < 8; i++) begin
            if (e[i]) r = gf_mul(r, p);
            p = gf_mul(p, p);
        end
        return r;
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] b;
        b = gf_inv(a);
        return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]}
                 ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
    endfunction

    logic [7:0]  rcon;
    logic [31:0] w0, w1, w2, w3;
    logic [31:0] rot, temp;
    logic [31:0] n0, n1, n2, n3;

    // Round constant for the round being generated.
    always_comb begin
        rcon = 8'h00;
        unique case (round)
            4'd0:    rcon = 8'h01;
            4'd1:    rcon = 8'h02;
            4'd2:    rcon = 8'h04;
            4'd3:    rcon = 8'h08;
            4'd4:    rcon = 8'h10;
            4'd5:    rcon = 8'h20;
            4'd6:    rcon = 8'h40;
            4'd7:    rcon = 8'h80;
            4'd8:    rcon = 8'h1b;
            4'd9:    rcon = 8'h36;
            default: rcon = 8'h00;
        endcase
    end

    // One AES-128 key schedule step: four new words from the previous four.
    always_comb begin
        {w0, w1, w2, w3} = key_in;
        rot  = {w3[23:0], w3[31:24]};
        temp = {sbox(rot[31:24]) ^ rcon, sbox(rot[23:16]),
                sbox(rot[15:8]), sbox(rot[7:0])};
        n0 = w0 ^ temp;
        n1 = w1 ^ n0;
        n2 = w2 ^ n1;
        n3 = w3 ^ n2;
        key_out = {n0, n1, n2, n3};
    end

endmodule

module round_key_store #(
    parameter bit REVERSE = 1'b1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [127:0] key_in,
    input  logic         key_valid,
    output logic         key_ready,
    output logic         busy,
    output logic         keys_ready,
    input  logic         rd_en,
    input  logic [3:0]   rd_idx,
    output logic [127:0] rd_key,
    output logic         rd_valid,
    output logic         rd_err
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        EXPAND = 2'd1,
        READY  = 2'd2
    } state_t;

    state_t       state;
    state_t       state_nxt;
    logic [3:0]   cnt;
    logic [127:0] slot [0:10];
    logic [127:0] gen_out;
    logic [3:0]   ridx;
    logic         load;

    assign load = key_valid && key_ready;
    assign ridx = REVERSE ? (4'd10 - rd_idx) : rd_idx;

    key_gen u_key_gen (
        .round   (cnt),
        .key_in  (slot[cnt]),
        .key_out (gen_out)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state: loads are only taken outside EXPAND.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (load) state_nxt = EXPAND;
            EXPAND:  if (cnt == 4'd9) state_nxt = READY;
            READY:   if (load) state_nxt = EXPAND;
            default: state_nxt = IDLE;
        endcase
    end

    // Status outputs decoded from state.
    always_comb begin
        key_ready  = 1'b1;
        busy       = 1'b0;
        keys_ready = 1'b0;
        unique case (state)
            IDLE:    ;
            EXPAND:  begin key_ready = 1'b0; busy = 1'b1; end
            READY:   keys_ready = 1'b1;
            default: ;
        endcase
    end

    // Round counter for the expansion walk.
    always_ff @(posedge clk) begin
        if (rst)                  cnt <= 4'd0;
        else if (load)            cnt <= 4'd0;
        else if (state == EXPAND) cnt <= cnt + 4'd1;
    end

    // Slot file: no reset, a fresh load rewrites every entry.
    always_ff @(posedge clk) begin
        if (!rst && load) slot[0] <= key_in;
        for (int i = 1; i < 11; i++) begin
            if (!rst && state == EXPAND && cnt == 4'(i - 1))
                slot[i] <= gen_out;
        end
    end

    // Registered read port, judged on pre-edge state.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_key   <= '0;
            rd_valid <= 1'b0;
            rd_err   <= 1'b0;
        end else begin
            rd_valid <= rd_en;
            rd_err   <= 1'b0;
            if (rd_en) begin
                if (rd_idx > 4'd10 || !keys_ready) begin
                    rd_key <= '0;
                    rd_err <= 1'b1;
                end else begin
                    rd_key <= slot[ridx];
                end
            end
        end
    end

endmodule

// File: tb/tb_round_key_store.sv
// Directed bench for round_key_store.
// Two instances share stimulus: forward (REVERSE=0) and decrypt order (REVERSE=1).

module tb_round_key_store;

    logic         clk = 1'b0;
    logic         rst;
    logic [127:0] key_in;
    logic         key_valid;
    logic         rd_en;
    logic [3:0]   rd_idx;

    logic         kr0, bz0, ks0, rv0, re0;
    logic [127:0] rk0;
    logic         kr1, bz1, ks1, rv1, re1;
    logic [127:0] rk1;

    int tests  = 0;
    int failed = 0;

    logic [127:0] fips [0:10];
    logic [127:0] zk1, zk10;
    logic [127:0] kf;

    always #5 clk = ~clk;

    round_key_store #(.REVERSE(1'b0)) dut0 (
        .clk(clk), .rst(rst), .key_in(key_in), .key_valid(key_valid),
        .key_ready(kr0), .busy(bz0), .keys_ready(ks0),
        .rd_en(rd_en), .rd_idx(rd_idx),
        .rd_key(rk0), .rd_valid(rv0), .rd_err(re0)
    );

    round_key_store #(.REVERSE(1'b1)) dut1 (
        .clk(clk), .rst(rst), .key_in(key_in), .key_valid(key_valid),
        .key_ready(kr1), .busy(bz1), .keys_ready(ks1),
        .rd_en(rd_en), .rd_idx(rd_idx),
        .rd_key(rk1), .rd_valid(rv1), .rd_err(re1)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs,
                       input logic [127:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic rd(input logic [3:0] idx);
        rd_en  = 1'b1;
        rd_idx = idx;
        tick();
        rd_en  = 1'b0;
    endtask

    task automatic load(input logic [127:0] k);
        key_in    = k;
        key_valid = 1'b1;
        tick();
        key_valid = 1'b0;
    endtask

    initial begin
        fips[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
        fips[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
        fips[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
        fips[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
        fips[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
        fips[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
        fips[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
        fips[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
        fips[8]  = 128'head27321b58dbad2312bf5607f8d292f;
        fips[9]  = 128'hac7766f319fadc2128d12941575c006e;
        fips[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
        zk1      = 128'h62636363626363636263636362636363;
        zk10     = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;
        kf       = fips[0];

        rst = 1'b1; key_in = '0; key_valid = 1'b0;
        rd_en = 1'b0; rd_idx = 4'd0;
        tick();
        tick();
        rst = 1'b0;

        chk("rst_key_ready", 128'(kr0), 128'(1'b1));
        chk("rst_busy", 128'(bz0), 128'(1'b0));
        chk("rst_keys_ready", 128'(ks0), 128'(1'b0));
        chk("rst_rd_valid", 128'(rv0), 128'(1'b0));
        chk("rst_rd_err", 128'(re0), 128'(1'b0));
        chk("rst_rd_key", rk0, 128'h0);

        // FIPS-197 key, extra key_valid during EXPAND must be ignored
        load(kf);
        chk("load_busy", 128'(bz0), 128'(1'b1));
        chk("load_key_ready", 128'(kr0), 128'(1'b0));
        chk("load_keys_ready", 128'(ks0), 128'(1'b0));
        rd(4'd1);
        chk("exp_rd_valid", 128'(rv0), 128'(1'b1));
        chk("exp_rd_err", 128'(re0), 128'(1'b1));
        chk("exp_rd_key", rk0, 128'h0);
        key_in = '0;
        key_valid = 1'b1;
        tick();
        tick();
        key_valid = 1'b0;
        for (int i = 4; i <= 9; i++) tick();
        chk("lat_ks_at9", 128'(ks0), 128'(1'b0));
        tick();
        chk("lat_ks_at10", 128'(ks0), 128'(1'b1));
        chk("lat_busy_at10", 128'(bz0), 128'(1'b0));
        chk("lat_kr_at10", 128'(kr0), 128'(1'b1));

        rd(4'd1);
        chk("f_r1_fwd", rk0, fips[1]);
        chk("f_r1_rev", rk1, fips[9]);
        chk("f_r1_err", 128'(re0), 128'(1'b0));
        tick();
        chk("idle_rd_valid", 128'(rv0), 128'(1'b0));
        chk("idle_hold", rk0, fips[1]);
        rd(4'd10);
        chk("f_r10_fwd", rk0, fips[10]);
        chk("f_r10_rev", rk1, fips[0]);
        rd(4'd0);
        chk("f_r0_fwd", rk0, fips[0]);
        chk("f_r0_rev", rk1, fips[10]);
        rd(4'd11);
        chk("oob_valid", 128'(rv0), 128'(1'b1));
        chk("oob_err", 128'(re0), 128'(1'b1));
        chk("oob_key", rk0, 128'h0);
        chk("oob_err_rev", 128'(re1), 128'(1'b1));

        // Reload from READY with the all-zero key
        load(128'h0);
        chk("z_ks_drop", 128'(ks0), 128'(1'b0));
        for (int i = 1; i <= 9; i++) tick();
        chk("z_ks_at9", 128'(ks0), 128'(1'b0));
        tick();
        chk("z_ks_at10", 128'(ks0), 128'(1'b1));
        rd(4'd1);
        chk("z_r1", rk0, zk1);
        rd(4'd10);
        chk("z_r10", rk0, zk10);

        // Reset mid-expansion of A (zero), then load B (FIPS)
        load(128'h0);
        for (int i = 1; i <= 5; i++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rst_ks", 128'(ks0), 128'(1'b0));
        chk("mid_rst_busy", 128'(bz0), 128'(1'b0));
        chk("mid_rst_kr", 128'(kr0), 128'(1'b1));
        load(kf);
        for (int i = 1; i <= 9; i++) begin
            tick();
            chk($sformatf("mid_ks_low_%0d", i), 128'(ks0), 128'(1'b0));
        end
        tick();
        chk("mid_ks_at10", 128'(ks0), 128'(1'b1));
        for (int i = 0; i <= 10; i++) begin
            rd(4'(i));
            chk($sformatf("slot_fwd_%0d", i), rk0, fips[i]);
            chk($sformatf("slot_rev_%0d", i), rk1, fips[10 - i]);
        end

        // Same-edge read and reload: A=FIPS in READY, B=zero
        key_in    = 128'h0;
        key_valid = 1'b1;
        rd_en     = 1'b1;
        rd_idx    = 4'd10;
        tick();
        key_valid = 1'b0;
        rd_en     = 1'b0;
        chk("same_rd_valid", 128'(rv0), 128'(1'b1));
        chk("same_rd_err", 128'(re0), 128'(1'b0));
        chk("same_rd_key", rk0, fips[10]);
        chk("same_rd_key_rev", rk1, fips[0]);
        chk("same_ks_drop", 128'(ks0), 128'(1'b0));
        for (int i = 1; i <= 9; i++) tick();
        chk("same_ks_at9", 128'(ks0), 128'(1'b0));
        tick();
        chk("same_ks_at10", 128'(ks0), 128'(1'b1));
        rd(4'd10);
        chk("same_b_r10", rk0, zk10);
        chk("same_b_r10_rev", rk1, 128'h0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
